// File: rtl/uart_tx_drv_pkg.sv
// +--------------------------------------------------------------------------+
// | Module  : uart_tx_drv_pkg                                                |
// | Brief   : Shared types, frame constants and parity helper for the UART   |
// |           transmitter driver.                                            |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

package uart_tx_drv_pkg;

  localparam int TICKS_PER_BIT = 16;
  localparam int DATA_BITS     = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_e;

  function automatic logic par_f(input logic [DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_drv_fifo.sv
// +--------------------------------------------------------------------------+
// | Module  : uart_tx_drv_fifo                                               |
// | Brief   : Synchronous byte FIFO with occupancy count; push while full    |
// |           and pop while empty are ignored.                               |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module uart_tx_drv_fifo
  import uart_tx_drv_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = DATA_BITS
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   lvl_o
);

  localparam int                c_AW   = $clog2(DEPTH);
  localparam logic [c_AW:0]     c_FULL = DEPTH[c_AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wptr;
  logic [c_AW-1:0]  r_rptr;
  logic [c_AW:0]    r_lvl;
  logic             w_push;
  logic             w_pop;

  assign full_o  = (r_lvl == c_FULL);
  assign empty_o = (r_lvl == '0);
  assign lvl_o   = r_lvl;
  assign data_o  = r_mem[r_rptr];
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;

  // Storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_lvl  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_lvl <= r_lvl + 1'b1;
        2'b01:   r_lvl <= r_lvl - 1'b1;
        default: r_lvl <= r_lvl;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_drv.sv
// +--------------------------------------------------------------------------+
// | Module  : uart_tx_drv                                                    |
// | Brief   : FIFO-buffered 8N1/8E1/8O1 UART transmitter with NCO baud tick. |
// |           Optional error injection: define UART_TX_DRV_ERR_INJ_EN.       |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module uart_tx_drv
  import uart_tx_drv_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int NCO_W      = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          tx_enable_i,
  input  logic                          parity_en_i,
  input  logic                          parity_odd_i,
  input  logic [NCO_W-1:0]              nco_i,
  input  logic [7:0]                    data_i,
  input  logic                          valid_i,
`ifdef UART_TX_DRV_ERR_INJ_EN
  input  logic                          inject_par_err_i,
  input  logic                          inject_stop_err_i,
`endif
  output logic                          ready_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_lvl_o,
  output logic                          busy_o,
  output logic                          frame_done_o,
  output logic                          tx_o
);

  localparam int                  c_TICK_W    = $clog2(TICKS_PER_BIT);
  localparam int                  c_BIT_W     = $clog2(DATA_BITS);
  localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICKS_PER_BIT - 1);
  localparam logic [c_BIT_W-1:0]  c_BIT_LAST  = c_BIT_W'(DATA_BITS - 1);

  uart_tx_state_e          r_state;
  uart_tx_state_e          w_state_nxt;
  logic [NCO_W-1:0]        r_acc;
  logic [NCO_W-1:0]        w_acc_nxt;
  logic                    w_tick;
  logic [c_TICK_W-1:0]     r_tick_cnt;
  logic [c_BIT_W-1:0]      r_bit_cnt;
  logic [DATA_BITS-1:0]    r_shift;
  logic                    r_par_en;
  logic                    r_par_bit;
  logic                    r_stop_err;
  logic                    r_tx;
  logic                    r_done;
  logic                    w_tx_nxt;
  logic                    w_done_nxt;
  logic                    w_adv;
  logic                    w_pop;
  logic                    w_can_start;
  logic                    w_full;
  logic                    w_empty;
  logic [DATA_BITS-1:0]    w_fifo_dout;
  logic                    w_inj_par;
  logic                    w_inj_stop;

`ifdef UART_TX_DRV_ERR_INJ_EN
  assign w_inj_par  = inject_par_err_i;
  assign w_inj_stop = inject_stop_err_i;
`else
  assign w_inj_par  = 1'b0;
  assign w_inj_stop = 1'b0;
`endif

  uart_tx_drv_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (valid_i),
    .data_i  (data_i),
    .pop_i   (w_pop),
    .data_o  (w_fifo_dout),
    .full_o  (w_full),
    .empty_o (w_empty),
    .lvl_o   (fifo_lvl_o)
  );

  // The x16 tick is the carry out of the accumulator add in the current cycle.
  assign {w_tick, w_acc_nxt} = {1'b0, r_acc} + {1'b0, nco_i};

  assign w_adv       = w_tick && (r_tick_cnt == c_TICK_LAST);
  assign w_can_start = !w_empty && tx_enable_i;
  assign ready_o     = !w_full;
  assign busy_o      = (r_state != IDLE);
  assign frame_done_o = r_done;
  assign tx_o        = r_tx;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_tx_nxt    = 1'b1;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_can_start) begin
          w_pop       = 1'b1;
          w_state_nxt = START;
        end
      end
      START: begin
        w_tx_nxt = 1'b0;
        if (w_adv) w_state_nxt = DATA;
      end
      DATA: begin
        w_tx_nxt = r_shift[0];
        if (w_adv && (r_bit_cnt == c_BIT_LAST)) begin
          w_state_nxt = r_par_en ? PARITY : STOP;
        end
      end
      PARITY: begin
        w_tx_nxt = r_par_bit;
        if (w_adv) w_state_nxt = STOP;
      end
      STOP: begin
        w_tx_nxt = !r_stop_err;
        if (w_adv) begin
          w_done_nxt = 1'b1;
          // Chain straight into the next start bit so queued bytes leave with no idle gap.
          if (w_can_start) begin
            w_pop       = 1'b1;
            w_state_nxt = START;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_acc      <= '0;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_stop_err <= 1'b0;
      r_tx       <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_acc  <= w_acc_nxt;
      r_tx   <= w_tx_nxt;
      r_done <= w_done_nxt;
      if (w_pop) begin
        r_tick_cnt <= '0;
        r_bit_cnt  <= '0;
        r_shift    <= w_fifo_dout;
        // Frame settings are captured here so mid-frame input changes cannot corrupt it.
        r_par_en   <= parity_en_i;
        r_par_bit  <= par_f(w_fifo_dout, parity_odd_i) ^ w_inj_par;
        r_stop_err <= w_inj_stop;
      end else begin
        if (w_tick) r_tick_cnt <= r_tick_cnt + 1'b1;
        if ((r_state == DATA) && w_adv) begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
          r_shift   <= r_shift >> 1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_drv.sv
// +--------------------------------------------------------------------------+
// | Module  : tb_uart_tx_drv                                                 |
// | Brief   : Self-checking bench: line-level UART receiver model decodes   |
// |           tx_o and compares against frames predicted from pushed bytes. |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_uart_tx_drv;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        tx_enable_i;
  logic        parity_en_i;
  logic        parity_odd_i;
  logic [15:0] nco_i;
  logic [7:0]  data_i;
  logic        valid_i;
  logic        ready_o;
  logic [3:0]  fifo_lvl_o;
  logic        busy_o;
  logic        frame_done_o;
  logic        tx_o;

  always #5 clk_i = ~clk_i;

  uart_tx_drv #(.FIFO_DEPTH(8), .NCO_W(16)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .tx_enable_i       (tx_enable_i),
    .parity_en_i       (parity_en_i),
    .parity_odd_i      (parity_odd_i),
    .nco_i             (nco_i),
    .data_i            (data_i),
    .valid_i           (valid_i),
`ifdef UART_TX_DRV_ERR_INJ_EN
    .inject_par_err_i  (1'b0),
    .inject_stop_err_i (1'b0),
`endif
    .ready_o           (ready_o),
    .fifo_lvl_o        (fifo_lvl_o),
    .busy_o            (busy_o),
    .frame_done_o      (frame_done_o),
    .tx_o              (tx_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Receiver model: frame = {stop, parity, data}
  bit         mon_en  = 1'b1;
  int         mon_p   = 32;
  bit         mon_par = 1'b0;
  logic [9:0] rx_q[$];
  logic [9:0] exp_q[$];
  int         fall_q[$];

  initial begin : monitor
    logic       prev;
    logic [7:0] b;
    logic       p;
    logic       s;
    int         per;
    bit         pe;
    prev = 1'b1;
    forever begin
      @(negedge clk_i);
      if (mon_en && prev === 1'b1 && tx_o === 1'b0) begin
        per = mon_p;
        pe  = mon_par;
        fall_q.push_back(cyc);
        repeat (per / 2) @(negedge clk_i);
        for (int i = 0; i < 8; i++) begin
          repeat (per) @(negedge clk_i);
          b[i] = tx_o;
        end
        p = 1'b0;
        if (pe) begin
          repeat (per) @(negedge clk_i);
          p = tx_o;
        end
        repeat (per) @(negedge clk_i);
        s = tx_o;
        rx_q.push_back({s, p, b});
      end
      prev = tx_o;
    end
  end

  function automatic logic [9:0] frame_exp(input logic [7:0] d, input bit pe, input bit odd);
    bit p;
    p = pe ? ((($countones(d) % 2) == 1) ^ odd) : 1'b0;
    return {1'b1, p, d};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Holds valid_i until the byte is accepted; the model records the expected frame.
  task automatic push(input logic [7:0] d);
    logic r;
    int   n;
    n = 0;
    valid_i = 1'b1;
    data_i  = d;
    do begin
      r = ready_o;
      step(1);
      n++;
    end while (!r && n < 20000);
    valid_i = 1'b0;
    checks++;
    assert (r === 1'b1) else begin
      errors++;
      $error("FAIL push_timeout: observed ready 0 expected ready 1");
    end
    exp_q.push_back(frame_exp(d, parity_en_i, parity_odd_i));
  endtask

  task automatic wait_done(output int t);
    int n;
    n = 0;
    t = -1;
    while (n < 5000) begin
      step(1);
      n++;
      if (frame_done_o === 1'b1) begin
        t = cyc;
        break;
      end
    end
    checks++;
    assert (t >= 0) else begin
      errors++;
      $error("FAIL done_timeout: observed no frame_done expected pulse");
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (!(busy_o === 1'b0 && fifo_lvl_o === 4'd0) && n < 20000) begin
      step(1);
      n++;
    end
    checks++;
    assert (n < 20000) else begin
      errors++;
      $error("FAIL drain_timeout: observed busy %0b lvl %0d expected idle", busy_o, fifo_lvl_o);
    end
    step(4);
  endtask

  task automatic check_rx(input string tag);
    logic [9:0] o;
    logic [9:0] e;
    chk({tag, "_count"}, rx_q.size(), exp_q.size());
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      o = rx_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, "_frame"}, {22'd0, o}, {22'd0, e});
    end
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin : stim
    int   t0;
    int   td;
    logic v;
    bit   frz_ok;
    logic [7:0] rb;

    rst_i        = 1'b1;
    tx_enable_i  = 1'b1;
    parity_en_i  = 1'b0;
    parity_odd_i = 1'b0;
    nco_i        = 16'h8000;
    data_i       = 8'h00;
    valid_i      = 1'b0;

    // Reset state
    step(2);
    chk("rst_tx", tx_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", frame_done_o, 0);
    chk("rst_lvl", fifo_lvl_o, 0);
    chk("rst_ready", ready_o, 1);
    rst_i = 1'b0;
    step(1);

    // Single 8N1 frame, latency and length
    mon_p = 32; mon_par = 1'b0;
    push(8'h55);
    step(1);
    chk("t1_tx_at_pop", tx_o, 1);
    chk("t1_busy", busy_o, 1);
    step(1);
    chk("t1_tx_start", tx_o, 0);
    t0 = cyc;
    wait_done(td);
    chk("t1_frame_len", ((td - t0) == 319 || (td - t0) == 318), 1);
    step(1);
    chk("t1_busy_after", busy_o, 0);
    drain();
    check_rx("t1");

    // Even and odd parity; parity sense latched at pop
    parity_en_i = 1'b1; parity_odd_i = 1'b0; mon_par = 1'b1;
    push(8'h07);
    wait_done(td);
    chk("t2_frame_len", ((td - fall_q[$]) == 351 || (td - fall_q[$]) == 350), 1);
    drain();
    parity_odd_i = 1'b1;
    push(8'h07);
    step(3);
    parity_odd_i = 1'b0;
    drain();
    check_rx("t2");
    parity_en_i = 1'b0; mon_par = 1'b0;

    // FIFO fill, drop while full, contiguous frames
    tx_enable_i = 1'b0;
    for (int i = 0; i < 8; i++) push(8'(i));
    chk("t3_lvl_full", fifo_lvl_o, 8);
    chk("t3_ready_full", ready_o, 0);
    valid_i = 1'b1; data_i = 8'h08;
    step(1);
    chk("t3_drop_lvl", fifo_lvl_o, 8);
    fall_q.delete();
    tx_enable_i = 1'b1;
    push(8'h08);
    drain();
    chk("t3_falls", fall_q.size(), 9);
    for (int i = 1; i < 9 && i < fall_q.size(); i++) chk("t3_gap", fall_q[i] - fall_q[i-1], 320);
    check_rx("t3");

    // Push and pop in the same cycle
    tx_enable_i = 1'b0;
    push(8'hC3);
    tx_enable_i = 1'b1;
    valid_i = 1'b1; data_i = 8'h3C;
    step(1);
    valid_i = 1'b0;
    exp_q.push_back(frame_exp(8'h3C, 1'b0, 1'b0));
    chk("t3_pushpop_lvl", fifo_lvl_o, 1);
    drain();
    check_rx("t3pp");

    // Reset mid-DATA
    push(8'hA5);
    push(8'h3C);
    step(32 * 3);
    rst_i = 1'b1;
    step(1);
    rst_i = 1'b0;
    chk("t4_tx", tx_o, 1);
    chk("t4_lvl", fifo_lvl_o, 0);
    chk("t4_busy", busy_o, 0);
    step(600);
    rx_q.delete(); exp_q.delete(); fall_q.delete();
    rb = 8'($urandom);
    push(rb);
    drain();
    check_rx("t4");

    // Enable dropped mid-frame with bytes queued
    push(8'h11); push(8'h22); push(8'h33);
    step(32 * 4);
    chk("t5_lvl_q", fifo_lvl_o, 2);
    tx_enable_i = 1'b0;
    wait_done(td);
    step(100);
    chk("t5_lvl_hold", fifo_lvl_o, 2);
    chk("t5_busy", busy_o, 0);
    chk("t5_rx_one", rx_q.size(), 1);
    tx_enable_i = 1'b1;
    drain();
    check_rx("t5");

    // nco_i = 0 freezes the line mid-bit
    mon_en = 1'b0;
    push(8'h96);
    exp_q.delete();
    step(32 * 3 + 5);
    nco_i = 16'h0000;
    step(2);
    v = tx_o;
    frz_ok = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (tx_o !== v || frame_done_o !== 1'b0 || busy_o !== 1'b1) frz_ok = 1'b0;
    end
    chk("t5_nco0_freeze", frz_ok, 1);
    nco_i = 16'h8000;
    drain();
    chk("t5_tx_idle", tx_o, 1);
    mon_en = 1'b1;

    // Randomised bytes and frame formats
    for (int k = 0; k < 3; k++) begin
      nco_i        = ($urandom_range(0, 1) == 0) ? 16'h8000 : 16'h4000;
      parity_en_i  = 1'($urandom_range(0, 1));
      parity_odd_i = 1'($urandom_range(0, 1));
      mon_p        = 16 * 65536 / int'(nco_i);
      mon_par      = parity_en_i;
      for (int j = 0; j < 4; j++) push(8'($urandom));
      drain();
      check_rx("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
